// File: rtl/shadow_dcache_arbiter_pkg.sv
// Shared types for the shadow dcache arbiter: source/state encodings and the
// default cache request/response structs used when no core types are supplied.
package shadow_dcache_arbiter_pkg;

    localparam int unsigned XLEN     = 32;
    localparam int unsigned IDX_W    = 12;
    localparam int unsigned TAG_W    = 20;
    localparam int unsigned ID_W     = 2;
    localparam int unsigned USER_W   = 1;

    typedef enum logic [1:0] {
        SRC_SAVE = 2'd0,
        SRC_LOAD = 2'd1,
        SRC_LSU  = 2'd2
    } arb_src_e;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REQ      = 2'd1,
        TAG_WAIT = 2'd2
    } arb_state_e;

    typedef struct packed {
        logic [IDX_W-1:0]  address_index;
        logic [TAG_W-1:0]  address_tag;
        logic [XLEN-1:0]   data_wdata;
        logic [USER_W-1:0] data_wuser;
        logic              data_req;
        logic              data_we;
        logic [XLEN/8-1:0] data_be;
        logic [1:0]        data_size;
        logic [ID_W-1:0]   data_id;
        logic              kill_req;
        logic              tag_valid;
    } dcache_req_t;

    typedef struct packed {
        logic              data_gnt;
        logic              data_rvalid;
        logic [ID_W-1:0]   data_rid;
        logic [XLEN-1:0]   data_rdata;
        logic [USER_W-1:0] data_ruser;
    } dcache_rsp_t;

endpackage

// File: rtl/shadow_dcache_arbiter_fifo.sv
// In-order FIFO of requester IDs for granted reads awaiting rvalid.
module shadow_src_fifo
    import shadow_dcache_arbiter_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    localparam int unsigned CW   = $clog2(DEPTH + 1),
    localparam int unsigned PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_push,
    input  logic          i_pop,
    input  logic [1:0]    i_data,
    output logic [1:0]    o_data,
    output logic          o_full,
    output logic          o_empty,
    output logic [CW-1:0] o_count
);

    logic [1:0]    r_mem [DEPTH];
    logic [PW-1:0] r_wr;
    logic [PW-1:0] r_rd;
    logic [CW-1:0] r_count;
    logic          w_do_push;
    logic          w_do_pop;

    assign o_full    = (r_count == CW'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_data    = r_mem[r_rd];
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);

    always_ff @(posedge i_clk) begin
        if (w_do_push) begin
            r_mem[r_wr] <= i_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) begin
                r_wr <= (r_wr == PW'(DEPTH - 1)) ? '0 : r_wr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd <= (r_rd == PW'(DEPTH - 1)) ? '0 : r_rd + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/shadow_dcache_arbiter.sv
// Merges shadow save, shadow reload and LSU requests onto one dcache port and
// steers read responses back to their requester in grant order.
module shadow_dcache_arbiter
    import shadow_dcache_arbiter_pkg::*;
#(
    parameter type         dcache_req_i_t = dcache_req_t,
    parameter type         dcache_req_o_t = dcache_rsp_t,
    parameter int unsigned NR_OUTSTANDING = 2,
    parameter int unsigned MAX_SHRU_BURST = 4
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  dcache_req_i_t save_req_i,
    output dcache_req_o_t save_rsp_o,
    input  dcache_req_i_t load_req_i,
    output dcache_req_o_t load_rsp_o,
    input  dcache_req_i_t lsu_req_i,
    output dcache_req_o_t lsu_rsp_o,
    output dcache_req_i_t dcache_req_o,
    input  dcache_req_o_t dcache_rsp_i,
    output logic          busy_o
);

    localparam int unsigned BW = $clog2(MAX_SHRU_BURST + 1);
    localparam int unsigned CW = $clog2(NR_OUTSTANDING + 1);

    arb_state_e    r_state;
    arb_state_e    w_state_nxt;
    arb_src_e      r_owner;
    arb_src_e      w_owner_nxt;
    logic [BW-1:0] r_burst;

    logic          w_fifo_full;
    logic          w_fifo_empty;
    logic [CW-1:0] w_fifo_count;
    logic [1:0]    w_fifo_head_raw;
    arb_src_e      w_fifo_head;

    logic          w_save_ok;
    logic          w_load_ok;
    logic          w_lsu_ok;
    arb_src_e      w_win;
    logic          w_win_any;
    arb_src_e      w_sel;
    dcache_req_i_t w_sel_req;
    logic          w_sel_ok;
    dcache_req_i_t w_dreq;
    logic          w_gnt;
    logic          w_push;
    logic          w_pop;
    logic          w_to_tag;

    // Reads are held back once every outstanding slot is in use; writes never are.
    assign w_save_ok = save_req_i.data_req && (save_req_i.data_we || !w_fifo_full);
    assign w_load_ok = load_req_i.data_req && (load_req_i.data_we || !w_fifo_full);
    assign w_lsu_ok  = lsu_req_i.data_req  && (lsu_req_i.data_we  || !w_fifo_full);

    always_comb begin
        w_win     = SRC_SAVE;
        w_win_any = 1'b0;
        if ((r_burst == BW'(MAX_SHRU_BURST)) && lsu_req_i.data_req) begin
            w_win     = SRC_LSU;
            w_win_any = 1'b1;
        end else if (w_save_ok) begin
            w_win     = SRC_SAVE;
            w_win_any = 1'b1;
        end else if (w_load_ok) begin
            w_win     = SRC_LOAD;
            w_win_any = 1'b1;
        end else if (w_lsu_ok) begin
            w_win     = SRC_LSU;
            w_win_any = 1'b1;
        end
    end

    always_comb begin
        w_sel = SRC_SAVE;
        case (r_state)
            IDLE:     w_sel = w_win;
            REQ:      w_sel = r_owner;
            TAG_WAIT: w_sel = SRC_LSU;
            default:  w_sel = SRC_SAVE;
        endcase
    end

    always_comb begin
        w_sel_req = '0;
        w_sel_ok  = 1'b0;
        case (w_sel)
            SRC_SAVE: begin w_sel_req = save_req_i; w_sel_ok = w_save_ok; end
            SRC_LOAD: begin w_sel_req = load_req_i; w_sel_ok = w_load_ok; end
            SRC_LSU:  begin w_sel_req = lsu_req_i;  w_sel_ok = w_lsu_ok;  end
            default:  begin w_sel_req = '0;         w_sel_ok = 1'b0;      end
        endcase
    end

    // TAG_WAIT forwards the LSU's late tag fields with data_req held low.
    always_comb begin
        w_dreq = '0;
        case (r_state)
            IDLE: begin
                if (w_win_any) begin
                    w_dreq          = w_sel_req;
                    w_dreq.data_req = w_sel_ok;
                end
            end
            REQ: begin
                w_dreq          = w_sel_req;
                w_dreq.data_req = w_sel_ok;
            end
            TAG_WAIT: begin
                w_dreq          = lsu_req_i;
                w_dreq.data_req = 1'b0;
            end
            default: w_dreq = '0;
        endcase
    end

    assign dcache_req_o = w_dreq;
    assign w_gnt        = dcache_rsp_i.data_gnt && w_dreq.data_req;
    assign w_push       = w_gnt && !w_dreq.data_we;
    assign w_pop        = dcache_rsp_i.data_rvalid && !w_fifo_empty;
    assign w_to_tag     = (w_sel == SRC_LSU) && !w_dreq.data_we && !lsu_req_i.tag_valid;
    assign w_fifo_head  = arb_src_e'(w_fifo_head_raw);
    assign busy_o       = (r_state != IDLE) || (w_fifo_count != '0);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= IDLE;
            r_owner <= SRC_SAVE;
        end else begin
            r_state <= w_state_nxt;
            r_owner <= w_owner_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_owner_nxt = r_owner;
        case (r_state)
            IDLE: begin
                if (w_win_any) begin
                    if (w_gnt) begin
                        w_state_nxt = w_to_tag ? TAG_WAIT : IDLE;
                    end else begin
                        w_state_nxt = REQ;
                        w_owner_nxt = w_win;
                    end
                end
            end
            REQ: begin
                if (!w_sel_req.data_req) begin
                    w_state_nxt = IDLE;
                end else if (w_gnt) begin
                    w_state_nxt = w_to_tag ? TAG_WAIT : IDLE;
                end
            end
            TAG_WAIT: begin
                if (lsu_req_i.tag_valid || lsu_req_i.kill_req) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        save_rsp_o = '0;
        load_rsp_o = '0;
        lsu_rsp_o  = '0;
        case (w_sel)
            SRC_SAVE: save_rsp_o.data_gnt = w_gnt;
            SRC_LOAD: load_rsp_o.data_gnt = w_gnt;
            SRC_LSU:  lsu_rsp_o.data_gnt  = w_gnt;
            default:  ;
        endcase
        if (w_pop) begin
            case (w_fifo_head)
                SRC_SAVE: begin
                    save_rsp_o.data_rvalid = 1'b1;
                    save_rsp_o.data_rdata  = dcache_rsp_i.data_rdata;
                    save_rsp_o.data_rid    = dcache_rsp_i.data_rid;
                    save_rsp_o.data_ruser  = dcache_rsp_i.data_ruser;
                end
                SRC_LOAD: begin
                    load_rsp_o.data_rvalid = 1'b1;
                    load_rsp_o.data_rdata  = dcache_rsp_i.data_rdata;
                    load_rsp_o.data_rid    = dcache_rsp_i.data_rid;
                    load_rsp_o.data_ruser  = dcache_rsp_i.data_ruser;
                end
                SRC_LSU: begin
                    lsu_rsp_o.data_rvalid = 1'b1;
                    lsu_rsp_o.data_rdata  = dcache_rsp_i.data_rdata;
                    lsu_rsp_o.data_rid    = dcache_rsp_i.data_rid;
                    lsu_rsp_o.data_ruser  = dcache_rsp_i.data_ruser;
                end
                default: ;
            endcase
        end
    end

    // Counts shadow grants taken while the LSU waits; any LSU grant or idle LSU resets it.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_burst <= '0;
        end else if (!lsu_req_i.data_req || (w_gnt && (w_sel == SRC_LSU))) begin
            r_burst <= '0;
        end else if (w_gnt && (r_burst != BW'(MAX_SHRU_BURST))) begin
            r_burst <= r_burst + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            assert (!(dcache_rsp_i.data_rvalid && w_fifo_empty))
                else $warning("shadow_dcache_arbiter: rvalid with empty source FIFO dropped");
        end
    end

    shadow_src_fifo #(
        .DEPTH (NR_OUTSTANDING)
    ) u_src_fifo (
        .i_clk   (clk_i),
        .i_rst   (rst_i),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_data  (w_sel),
        .o_data  (w_fifo_head_raw),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_count (w_fifo_count)
    );

endmodule

// File: tb/tb_shadow_dcache_arbiter.sv
// Directed bench for shadow_dcache_arbiter with hand-computed expectations.
module tb_shadow_dcache_arbiter;
    import shadow_dcache_arbiter_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    dcache_req_t save_req, load_req, lsu_req, dc_req;
    dcache_rsp_t save_rsp, load_rsp, lsu_rsp, dc_rsp;
    logic        busy;
    int          total = 0;
    int          bad   = 0;

    always #5 clk = ~clk;

    shadow_dcache_arbiter #(
        .dcache_req_i_t (dcache_req_t),
        .dcache_req_o_t (dcache_rsp_t),
        .NR_OUTSTANDING (2),
        .MAX_SHRU_BURST (4)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .save_req_i   (save_req),
        .save_rsp_o   (save_rsp),
        .load_req_i   (load_req),
        .load_rsp_o   (load_rsp),
        .lsu_req_i    (lsu_req),
        .lsu_rsp_o    (lsu_rsp),
        .dcache_req_o (dc_req),
        .dcache_rsp_i (dc_rsp),
        .busy_o       (busy)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp)
            else begin
                bad++;
                $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
            end
    endtask

    function automatic dcache_req_t mkreq(input logic req, input logic we, input logic [11:0] idx,
                                          input logic [19:0] tag, input logic tv);
        dcache_req_t r;
        r               = '0;
        r.data_req      = req;
        r.data_we       = we;
        r.address_index = idx;
        r.address_tag   = tag;
        r.tag_valid     = tv;
        r.data_be       = '1;
        r.data_size     = 2'd2;
        return r;
    endfunction

    function automatic dcache_rsp_t mkrsp(input logic gnt, input logic rv, input logic [1:0] rid,
                                          input logic [31:0] rdata);
        dcache_rsp_t r;
        r             = '0;
        r.data_gnt    = gnt;
        r.data_rvalid = rv;
        r.data_rid    = rid;
        r.data_rdata  = rdata;
        return r;
    endfunction

    initial begin
        rst      = 1'b1;
        save_req = '0;
        load_req = '0;
        lsu_req  = '0;
        dc_rsp   = '0;
        tick();
        tick();
        rst = 1'b0;
        #1;
        chk("rst_save_rsp", save_rsp, 0);
        chk("rst_load_rsp", load_rsp, 0);
        chk("rst_lsu_rsp", lsu_rsp, 0);
        chk("rst_dreq", dc_req.data_req, 0);
        chk("rst_busy", busy, 0);
        chk("rst_state", dut.r_state, IDLE);
        chk("rst_burst", dut.r_burst, 0);

        // save and LSU store together, gnt held high
        tick();
        save_req = mkreq(1, 1, 12'h010, 20'h0, 1);
        lsu_req  = mkreq(1, 1, 12'h020, 20'h0, 1);
        dc_rsp   = mkrsp(1, 0, 0, 0);
        #1;
        chk("t1c0_save_gnt", save_rsp.data_gnt, 1);
        chk("t1c0_lsu_gnt", lsu_rsp.data_gnt, 0);
        chk("t1c0_addr", dc_req.address_index, 12'h010);
        tick();
        save_req = '0;
        #1;
        chk("t1c1_save_gnt", save_rsp.data_gnt, 0);
        chk("t1c1_lsu_gnt", lsu_rsp.data_gnt, 1);
        chk("t1c1_addr", dc_req.address_index, 12'h020);
        chk("t1c1_burst", dut.r_burst, 1);
        tick();
        lsu_req = '0;
        dc_rsp  = '0;
        #1;
        chk("t1_burst_clr", dut.r_burst, 0);

        // shadow burst limit
        save_req = mkreq(1, 1, 12'h100, 20'h0, 1);
        load_req = mkreq(1, 0, 12'h200, 20'h0, 1);
        lsu_req  = mkreq(1, 1, 12'h300, 20'h0, 1);
        dc_rsp   = mkrsp(1, 0, 0, 0);
        for (int k = 0; k < 4; k++) begin
            #1;
            chk($sformatf("t2_slot%0d_save_gnt", k), save_rsp.data_gnt, 1);
            chk($sformatf("t2_slot%0d_lsu_gnt", k), lsu_rsp.data_gnt, 0);
            chk($sformatf("t2_slot%0d_burst", k), dut.r_burst, k);
            tick();
        end
        #1;
        chk("t2_slot4_burst", dut.r_burst, 4);
        chk("t2_slot4_lsu_gnt", lsu_rsp.data_gnt, 1);
        chk("t2_slot4_save_gnt", save_rsp.data_gnt, 0);
        chk("t2_slot4_addr", dc_req.address_index, 12'h300);
        tick();
        #1;
        chk("t2_burst_back0", dut.r_burst, 0);
        chk("t2_slot5_save_gnt", save_rsp.data_gnt, 1);
        chk("t2_load_never", load_rsp.data_gnt, 0);
        tick();
        save_req = '0;
        load_req = '0;
        lsu_req  = '0;
        dc_rsp   = '0;
        tick();

        // LSU read with late tag, save waits out the tag phase
        lsu_req = mkreq(1, 0, 12'h030, 20'h0, 0);
        dc_rsp  = mkrsp(1, 0, 0, 0);
        #1;
        chk("t3c0_lsu_gnt", lsu_rsp.data_gnt, 1);
        chk("t3c0_dreq", dc_req.data_req, 1);
        tick();
        lsu_req  = mkreq(0, 0, 12'h030, 20'h0, 0);
        save_req = mkreq(1, 1, 12'h040, 20'h0, 1);
        #1;
        chk("t3c1_state", dut.r_state, TAG_WAIT);
        chk("t3c1_save_gnt", save_rsp.data_gnt, 0);
        chk("t3c1_dreq", dc_req.data_req, 0);
        tick();
        lsu_req = mkreq(0, 0, 12'h030, 20'hABCDE, 1);
        #1;
        chk("t3c2_save_gnt", save_rsp.data_gnt, 0);
        chk("t3c2_dreq", dc_req.data_req, 0);
        chk("t3c2_tag", dc_req.address_tag, 20'hABCDE);
        chk("t3c2_tv", dc_req.tag_valid, 1);
        tick();
        lsu_req = '0;
        #1;
        chk("t3c3_save_gnt", save_rsp.data_gnt, 1);
        chk("t3c3_busy", busy, 1);
        tick();
        save_req = '0;
        dc_rsp   = mkrsp(0, 1, 2'd1, 32'hDEADBEEF);
        #1;
        chk("t3_lsu_rvalid", lsu_rsp.data_rvalid, 1);
        chk("t3_lsu_rdata", lsu_rsp.data_rdata, 32'hDEADBEEF);
        chk("t3_lsu_rid", lsu_rsp.data_rid, 1);
        chk("t3_save_rvalid", save_rsp.data_rvalid, 0);
        chk("t3_load_rvalid", load_rsp.data_rvalid, 0);
        tick();
        dc_rsp = '0;
        #1;
        chk("t3_busy_end", busy, 0);

        // two loads fill the FIFO, third waits for a pop
        load_req = mkreq(1, 0, 12'h040, 20'h0, 1);
        dc_rsp   = mkrsp(1, 0, 0, 0);
        #1;
        chk("t4_ld1_gnt", load_rsp.data_gnt, 1);
        tick();
        load_req = mkreq(1, 0, 12'h041, 20'h0, 1);
        #1;
        chk("t4_ld2_gnt", load_rsp.data_gnt, 1);
        tick();
        load_req = mkreq(1, 0, 12'h042, 20'h0, 1);
        #1;
        chk("t4_ld3_blk_dreq", dc_req.data_req, 0);
        chk("t4_ld3_blk_gnt", load_rsp.data_gnt, 0);
        tick();
        #1;
        chk("t4_ld3_blk2_dreq", dc_req.data_req, 0);
        tick();
        dc_rsp = mkrsp(1, 1, 0, 32'h1111);
        #1;
        chk("t4_pop1_rvalid", load_rsp.data_rvalid, 1);
        chk("t4_pop1_rdata", load_rsp.data_rdata, 32'h1111);
        chk("t4_pop1_nobypass", dc_req.data_req, 0);
        chk("t4_pop1_lsu_rvalid", lsu_rsp.data_rvalid, 0);
        tick();
        dc_rsp = mkrsp(1, 0, 0, 0);
        #1;
        chk("t4_ld3_dreq", dc_req.data_req, 1);
        chk("t4_ld3_gnt", load_rsp.data_gnt, 1);
        chk("t4_ld3_addr", dc_req.address_index, 12'h042);
        tick();
        load_req = '0;
        dc_rsp   = mkrsp(0, 1, 0, 32'h2222);
        #1;
        chk("t4_pop2_rdata", load_rsp.data_rdata, 32'h2222);
        chk("t4_pop2_save_rvalid", save_rsp.data_rvalid, 0);
        tick();
        dc_rsp = mkrsp(0, 1, 0, 32'h3333);
        #1;
        chk("t4_pop3_rvalid", load_rsp.data_rvalid, 1);
        chk("t4_pop3_rdata", load_rsp.data_rdata, 32'h3333);
        tick();
        dc_rsp = '0;
        #1;
        chk("t4_busy_end", busy, 0);

        // interleaved LSU then load reads, rvalids 3 cycles apart
        lsu_req = mkreq(1, 0, 12'h050, 20'h0, 0);
        dc_rsp  = mkrsp(1, 0, 0, 0);
        #1;
        chk("t5_lsu_gnt", lsu_rsp.data_gnt, 1);
        tick();
        lsu_req  = mkreq(0, 0, 12'h050, 20'h12345, 1);
        load_req = mkreq(1, 0, 12'h060, 20'h0, 1);
        #1;
        chk("t5_tagwait_load_gnt", load_rsp.data_gnt, 0);
        tick();
        lsu_req = '0;
        #1;
        chk("t5_load_gnt", load_rsp.data_gnt, 1);
        tick();
        load_req = '0;
        dc_rsp   = mkrsp(0, 1, 0, 32'hAAAA0001);
        #1;
        chk("t5_rv1_lsu", lsu_rsp.data_rvalid, 1);
        chk("t5_rv1_lsu_rdata", lsu_rsp.data_rdata, 32'hAAAA0001);
        chk("t5_rv1_load", load_rsp.data_rvalid, 0);
        tick();
        dc_rsp = '0;
        tick();
        tick();
        dc_rsp = mkrsp(0, 1, 0, 32'hBBBB0002);
        #1;
        chk("t5_rv2_load", load_rsp.data_rvalid, 1);
        chk("t5_rv2_load_rdata", load_rsp.data_rdata, 32'hBBBB0002);
        chk("t5_rv2_lsu", lsu_rsp.data_rvalid, 0);
        tick();
        dc_rsp = '0;
        #1;
        chk("t5_busy_end", busy, 0);
        chk("t5_fifo_empty", dut.w_fifo_empty, 1);

        // reset while in REQ with one read outstanding
        load_req = mkreq(1, 0, 12'h070, 20'h0, 1);
        dc_rsp   = mkrsp(1, 0, 0, 0);
        tick();
        load_req = '0;
        save_req = mkreq(1, 1, 12'h080, 20'h0, 1);
        dc_rsp   = '0;
        tick();
        #1;
        chk("t6_state_req", dut.r_state, REQ);
        chk("t6_req_addr", dc_req.address_index, 12'h080);
        chk("t6_req_save_gnt", save_rsp.data_gnt, 0);
        chk("t6_busy", busy, 1);
        rst = 1'b1;
        tick();
        rst      = 1'b0;
        save_req = '0;
        #1;
        chk("t6_post_state", dut.r_state, IDLE);
        chk("t6_post_busy", busy, 0);
        chk("t6_post_dreq", dc_req.data_req, 0);
        dc_rsp = mkrsp(0, 1, 0, 32'h5555);
        #1;
        chk("t6_drop_save", save_rsp, 0);
        chk("t6_drop_load", load_rsp, 0);
        chk("t6_drop_lsu", lsu_rsp, 0);
        tick();
        dc_rsp = '0;
        #1;
        chk("t6_end_busy", busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
